ram_port_arbiter: RTL and testbench

Shares the datapath's single-port 512×32 synchronous RAM between two requesters:
- the CPU memory path (MAR address, MDR write data, MDR read return);
- a DMA/loader port used for program load and debug readback.

The block sits between both requesters and the RAM, with round-robin fairness on simultaneous requests. It returns read data with a one-cycle `ack`, so `control_unit` stalls on `cpu_ack` instead of assuming fixed memory latency.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_pick2.sv | 26 ++
 rtl/ram_port_arbiter.sv | 117 +++++++++++
 tb/tb_ram_port_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package arb_pkg;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    // Arbiter FSM: one address cycle, one data-return cycle, then back to idle.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // Owner encoding used for both the current owner and the round-robin history.
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick between the CPU and DMA requests.
// Latency: purely combinational.
// Backpressure: none; callers mask requests before they reach this block.
module rr_pick2
    import arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dma_req,
    input  logic last_owner,
    output logic gnt_vld,
    output logic winner
);

    // On a tie the requester that did not own the RAM last time wins.
    always_comb begin
        gnt_vld = cpu_req | dma_req;
        if (cpu_req && dma_req) begin
            winner = ~last_owner;
        end else if (cpu_req) begin
            winner = OWN_CPU;
        end else begin
            winner = OWN_DMA;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous RAM between the CPU memory path and a DMA/loader port.
// Latency: request seen in C0 -> ACCESS C1 -> CAPTURE C2 -> one-cycle ack with rdata in C3.
// Backpressure: requesters hold req until their ack; req is ignored during its own ack cycle.
module ram_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = arb_pkg::ADDR_W,
    parameter int DATA_W = arb_pkg::DATA_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy
);

    state_t            state;
    logic              owner;
    logic              last_owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              cpu_mreq;
    logic              dma_mreq;
    logic              gnt_vld;
    logic              winner;

    // A requester may still be holding req in its ack cycle; that stale request must not re-grant.
    assign cpu_mreq = cpu_req & ~cpu_ack;
    assign dma_mreq = dma_req & ~dma_ack;

    rr_pick2 u_pick (
        .cpu_req    (cpu_mreq),
        .dma_req    (dma_mreq),
        .last_owner (last_owner),
        .gnt_vld    (gnt_vld),
        .winner     (winner)
    );

    // FSM sequencing and latching of the winning request at the grant edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_owner <= OWN_DMA;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        state      <= ACCESS;
                        owner      <= winner;
                        last_owner <= winner;
                        if (winner == OWN_CPU) begin
                            lat_we    <= cpu_we;
                            lat_addr  <= cpu_addr;
                            lat_wdata <= cpu_wdata;
                        end else begin
                            lat_we    <= dma_we;
                            lat_addr  <= dma_addr;
                            lat_wdata <= dma_wdata;
                        end
                    end
                end
                ACCESS:  state <= CAPTURE;
                CAPTURE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Completion: owner gets a one-cycle ack and its read data (zero for writes) on leaving CAPTURE.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cpu_ack   <= 1'b0;
            dma_ack   <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            if (state == CAPTURE) begin
                if (owner == OWN_CPU) begin
                    cpu_ack   <= 1'b1;
                    cpu_rdata <= lat_we ? '0 : ram_q;
                end else begin
                    dma_ack   <= 1'b1;
                    dma_rdata <= lat_we ? '0 : ram_q;
                end
            end
        end
    end

    // Address and data simply follow the latch; the write strobe is gated by Reset so an
    // interrupted access never commits.
    assign ram_addr = lat_addr;
    assign ram_data = lat_wdata;
    assign ram_we   = (state == ACCESS) & lat_we & ~Reset;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a behavioural RAM and a shadow-memory model.
// Latency: n/a (testbench).
// Backpressure: requesters in the bench hold req until ack, as the real clients do.
module tb_ram_port_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [8:0]  cpu_addr, dma_addr;
    logic [31:0] cpu_wdata, dma_wdata;
    logic        cpu_ack, dma_ack, ram_we, busy;
    logic [31:0] cpu_rdata, dma_rdata, ram_data;
    logic [8:0]  ram_addr;
    logic [31:0] ram_q;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mem     [0:511] = '{default: 32'h0};
    logic [31:0] ref_mem [0:511] = '{default: 32'h0};

    ram_port_arbiter dut (
        .Clock(Clock), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q),
        .busy(busy)
    );

    always #5 Clock = ~Clock;

    // Single-port synchronous RAM: read data appears the cycle after the address edge.
    always @(posedge Clock) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input int p, input logic r, input logic we, input logic [8:0] a,
                         input logic [31:0] d);
        if (p == 0) begin
            cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end else begin
            dma_req = r; dma_we = we; dma_addr = a; dma_wdata = d;
        end
    endtask

    // One isolated access from idle: checks latency, read data, write strobe and busy windows.
    task automatic do_op(input string tag, input int p, input logic we, input logic [8:0] a,
                         input logic [31:0] d);
        int          lat;
        int          we_bits;
        int          busy_bits;
        logic [31:0] exp;
        logic [31:0] rd;
        exp = we ? 32'h0 : ref_mem[a];
        lat = 0; we_bits = 0; busy_bits = 0;
        drive(p, 1'b1, we, a, d);
        while (lat < 20) begin
            tick();
            lat++;
            if (ram_we) we_bits |= (1 << lat);
            if (busy)   busy_bits |= (1 << lat);
            if ((p == 0) ? cpu_ack : dma_ack) break;
        end
        rd = (p == 0) ? cpu_rdata : dma_rdata;
        drive(p, 1'b0, 1'b0, 9'h0, 32'h0);
        if (we) ref_mem[a] = d;
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_rdata"}, rd, exp);
        chk({tag, "_we_window"}, we_bits, we ? 2 : 0);
        chk({tag, "_busy_window"}, busy_bits, 6);
        tick();
    endtask

    initial begin
        int          cyc;
        int          cpu_cyc, dma_cyc;
        int          n_acks;
        int          ack_port [6];
        int          ack_cyc  [6];
        logic        any_we, any_busy, any_ack;
        logic        pend [2];
        logic        pwe  [2];
        logic [8:0]  padr [2];
        logic [31:0] pdat [2];
        int          age  [2];
        logic        ack;
        logic [31:0] rd;

        Reset = 1'b1;
        drive(0, 1'b0, 1'b0, 9'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 9'h0, 32'h0);
        tick(); tick();
        Reset = 1'b0;
        #1;
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_dma_ack", dma_ack, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_data", ram_data, 0);
        chk("rst_busy", busy, 0);
        any_we = 0; any_busy = 0;
        repeat (5) begin
            tick();
            any_we   |= ram_we;
            any_busy |= busy;
        end
        chk("idle_no_we", any_we, 0);
        chk("idle_no_busy", any_busy, 0);

        // CPU write then read-back of the same word.
        do_op("cpu_wr", 0, 1'b1, 9'h1A5, 32'hDEADBEEF);
        do_op("cpu_rd", 0, 1'b0, 9'h1A5, 32'h0);

        // DMA preload, then a tie: CPU (last owner DMA) first, DMA three cycles later.
        do_op("dma_wr", 1, 1'b1, 9'h000, 32'h11111111);
        drive(0, 1'b1, 1'b0, 9'h000, 32'h0);
        drive(1, 1'b1, 1'b0, 9'h000, 32'h0);
        cyc = 0; cpu_cyc = -1; dma_cyc = -1;
        while (cyc < 20 && (cpu_cyc < 0 || dma_cyc < 0)) begin
            tick();
            cyc++;
            if (cpu_ack) begin
                cpu_cyc = cyc;
                chk("tie_cpu_rdata", cpu_rdata, ref_mem[0]);
                drive(0, 1'b0, 1'b0, 9'h0, 32'h0);
            end
            if (dma_ack) begin
                dma_cyc = cyc;
                chk("tie_dma_rdata", dma_rdata, ref_mem[0]);
                drive(1, 1'b0, 1'b0, 9'h0, 32'h0);
            end
        end
        chk("tie_cpu_cycle", cpu_cyc, 3);
        chk("tie_dma_cycle", dma_cyc, 6);
        tick();

        // Both requesters held continuously: strict alternation, acks three cycles apart.
        drive(0, 1'b1, 1'b0, 9'h1A5, 32'h0);
        drive(1, 1'b1, 1'b0, 9'h000, 32'h0);
        cyc = 0; n_acks = 0;
        while (cyc < 40 && n_acks < 6) begin
            tick();
            cyc++;
            if (cpu_ack) begin
                ack_port[n_acks] = 0; ack_cyc[n_acks] = cyc; n_acks++;
                chk("alt_cpu_rdata", cpu_rdata, ref_mem[9'h1A5]);
            end else if (dma_ack) begin
                ack_port[n_acks] = 1; ack_cyc[n_acks] = cyc; n_acks++;
                chk("alt_dma_rdata", dma_rdata, ref_mem[9'h000]);
            end
        end
        drive(0, 1'b0, 1'b0, 9'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 9'h0, 32'h0);
        chk("alt_count", n_acks, 6);
        for (int i = 0; i < n_acks; i++) begin
            chk($sformatf("alt_port_%0d", i), ack_port[i], i % 2);
            chk($sformatf("alt_cycle_%0d", i), ack_cyc[i], 3 * (i + 1));
        end
        repeat (4) tick();

        // Reset during the ACCESS cycle of a CPU write: nothing commits, no ack.
        drive(0, 1'b1, 1'b1, 9'h020, 32'hCAFEF00D);
        tick();
        chk("abort_in_access", busy, 1);
        Reset = 1'b1;
        #1;
        chk("abort_we_gated", ram_we, 0);
        tick();
        Reset = 1'b0;
        drive(0, 1'b0, 1'b0, 9'h0, 32'h0);
        #1;
        chk("abort_idle", busy, 0);
        any_ack = 0;
        repeat (4) begin
            tick();
            any_ack |= cpu_ack;
        end
        chk("abort_no_ack", any_ack, 0);
        do_op("abort_dma_rd", 1, 1'b0, 9'h020, 32'h0);

        // Single CPU requester holding req through its ack: ack cycle is masked, four-cycle spacing.
        drive(0, 1'b1, 1'b0, 9'h1A5, 32'h0);
        cyc = 0; n_acks = 0;
        while (cyc < 20 && n_acks < 2) begin
            tick();
            cyc++;
            if (cpu_ack) begin
                ack_cyc[n_acks] = cyc; n_acks++;
                chk("b2b_rdata", cpu_rdata, ref_mem[9'h1A5]);
            end
        end
        drive(0, 1'b0, 1'b0, 9'h0, 32'h0);
        chk("b2b_count", n_acks, 2);
        chk("b2b_first", ack_cyc[0], 3);
        chk("b2b_second", ack_cyc[1], 7);
        repeat (4) tick();

        // Random traffic on both ports against a shadow memory updated in completion order.
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; pwe[p] = 0; padr[p] = 0; pdat[p] = 0; age[p] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            tick();
            for (int p = 0; p < 2; p++) begin
                ack = (p == 0) ? cpu_ack : dma_ack;
                rd  = (p == 0) ? cpu_rdata : dma_rdata;
                if (ack) begin
                    chk($sformatf("rnd_ack_expected_p%0d", p), pend[p], 1);
                    if (pend[p]) begin
                        chk($sformatf("rnd_rdata_p%0d_a%0h", p, padr[p]), rd,
                            pwe[p] ? 32'h0 : ref_mem[padr[p]]);
                        chk($sformatf("rnd_latency_ok_p%0d", p), age[p] <= 9, 1);
                        if (pwe[p]) ref_mem[padr[p]] = pdat[p];
                    end
                    pend[p] = 0;
                    drive(p, 1'b0, 1'b0, 9'h0, 32'h0);
                end else if (pend[p]) begin
                    age[p]++;
                end
                if (!pend[p] && c < 360 && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1;
                    age[p]  = 1;
                    pwe[p]  = $urandom_range(0, 1) == 1;
                    padr[p] = 9'($urandom_range(0, 7));
                    pdat[p] = $urandom;
                    drive(p, 1'b1, pwe[p], padr[p], pdat[p]);
                end
            end
        end
        chk("rnd_cpu_drained", pend[0], 0);
        chk("rnd_dma_drained", pend[1], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
